y86_mc_sequencer: RTL and testbench

- Multi-cycle stage sequencer for the Y86-64 core. Replaces free-running, clock-edge-only stage evaluation with an explicit FSM.
- Issues one-hot stage enables to fetch / decode / execute / memory / writeback / PC-update units.
- Handshakes with data memory and tracks architectural status (AOK/HLT/ADR/INS).
- Supports single-step debug and keeps cycle and instruction counters.

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/y86_mc_sequencer_if.sv | 9 +
 rtl/y86_sat_counter.sv | 20 ++
 rtl/y86_mc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_y86_mc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and sequencer states.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_PCUP,
      S_PAUSE,
      S_HALT
   } state_e;

   // Instructions that touch data memory and therefore pass through MEM.
   function automatic logic is_mem_icode(input logic [3:0] ic);
      return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
             (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
   endfunction

endpackage

// File: rtl/y86_mc_sequencer_if.sv
// Data memory request/completion handshake between the sequencer and data memory.
interface y86_mc_sequencer_if;
   logic mem_req;
   logic mem_rdy;
   logic dmem_error;

   modport master (output mem_req, input mem_rdy, input dmem_error);
   modport slave  (input mem_req, output mem_rdy, output dmem_error);
endinterface

// File: rtl/y86_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module y86_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   // Count while enabled; hold once every bit is set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/y86_mc_sequencer.sv
// Multi-cycle stage sequencer for the Y86-64 core.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | fetch unit enabled; imem_error / instr_valid checked here
// S_DECODE | decode unit enabled; halt instruction detected here
// S_EXEC   | execute unit enabled; cc_en for OPq
// S_MEM    | data memory access; waits for mem_rdy with timeout
// S_WB     | register writeback
// S_PCUP   | PC update; instruction retires on exit
// S_PAUSE  | single-step hold, released by step
// S_HALT   | terminal; only reset leaves
module y86_mc_sequencer
   import y86_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                step_mode,
   input  logic                step,
   input  logic [3:0]          icode,
   input  logic [3:0]          ifun,
   input  logic                instr_valid,
   input  logic                imem_error,
   y86_mc_sequencer_if.master  dmem,
   output logic                fetch_en,
   output logic                decode_en,
   output logic                exec_en,
   output logic                mem_en,
   output logic                wb_en,
   output logic                pc_en,
   output logic                cc_en,
   output logic [2:0]          stat,
   output logic                halted,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instr_cnt
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_e          state;
   state_e          state_nxt;
   logic [2:0]      stat_nxt;
   logic [TO_W-1:0] to_cnt;
   logic            cyc_en;
   logic            ret_en;

   // ifun travels with icode from the fetch unit but does not steer sequencing.
   logic unused_ifun;
   assign unused_ifun = ^ifun;

   // State and architectural status registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         stat  <= STAT_AOK;
      end else begin
         state <= state_nxt;
         stat  <= stat_nxt;
      end
   end

   // Next state and status; faults latch a status code and park in HALT.
   always_comb begin
      state_nxt = state;
      stat_nxt  = stat;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (imem_error) begin
               stat_nxt  = STAT_ADR;
               state_nxt = S_HALT;
            end else if (!instr_valid) begin
               stat_nxt  = STAT_INS;
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (icode == I_HALT) begin
               stat_nxt  = STAT_HLT;
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            state_nxt = is_mem_icode(icode) ? S_MEM : S_WB;
         end
         S_MEM: begin
            // A completion on the final allowed cycle takes priority over the timeout.
            if (dmem.mem_rdy) begin
               if (dmem.dmem_error) begin
                  stat_nxt  = STAT_ADR;
                  state_nxt = S_HALT;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (to_cnt == TO_LAST) begin
               stat_nxt  = STAT_ADR;
               state_nxt = S_HALT;
            end
         end
         S_WB: begin
            state_nxt = S_PCUP;
         end
         S_PCUP: begin
            state_nxt = step_mode ? S_PAUSE : S_FETCH;
         end
         S_PAUSE: begin
            if (step) state_nxt = S_FETCH;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Moore stage enables, memory request and counter enables.
   always_comb begin
      fetch_en     = (state == S_FETCH);
      decode_en    = (state == S_DECODE);
      exec_en      = (state == S_EXEC);
      mem_en       = (state == S_MEM);
      wb_en        = (state == S_WB);
      pc_en        = (state == S_PCUP);
      cc_en        = (state == S_EXEC) && (icode == I_OPQ);
      dmem.mem_req = (state == S_MEM);
      halted       = (state == S_HALT);
      cyc_en       = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                     (state == S_MEM)   || (state == S_WB)     || (state == S_PCUP);
      ret_en       = (state == S_PCUP);
   end

   // Memory wait counter: advances while MEM keeps waiting, clears when MEM is left.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if ((state == S_MEM) && (state_nxt == S_MEM)) begin
         to_cnt <= to_cnt + 1'b1;
      end else begin
         to_cnt <= '0;
      end
   end

   y86_sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cyc_en),
      .cnt   (cycle_cnt)
   );

   y86_sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ret_en),
      .cnt   (instr_cnt)
   );

endmodule

// File: tb/tb_y86_mc_sequencer.sv
// Directed bench for the Y86-64 multi-cycle stage sequencer.
module tb_y86_mc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        step_mode;
   logic        step;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic        instr_valid;
   logic        imem_error;
   logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en;
   logic [2:0]  stat;
   logic        halted;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
   logic        sat_en;
   logic [2:0]  sat_cnt;

   y86_mc_sequencer_if dmem_if ();

   y86_mc_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .step_mode   (step_mode),
      .step        (step),
      .icode       (icode),
      .ifun        (ifun),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .dmem        (dmem_if),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .exec_en     (exec_en),
      .mem_en      (mem_en),
      .wb_en       (wb_en),
      .pc_en       (pc_en),
      .cc_en       (cc_en),
      .stat        (stat),
      .halted      (halted),
      .cycle_cnt   (cycle_cnt),
      .instr_cnt   (instr_cnt)
   );

   y86_sat_counter #(.W(3)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (sat_en),
      .cnt   (sat_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // program and memory behaviour for run_prog
   int prog [8];
   int prog_len;
   int rdy_delay;      // MEM cycles before mem_rdy; -1 = never
   logic dmem_err_flag;
   logic valid_flag;
   logic imem_flag;

   // run_prog results
   int n_ticks, cc_cycles, memreq_cycles, max_run, n_fetch, fetch_tick2;
   int stat_at_fetch2;
   logic decode_seen;

   function automatic logic [8:0] outs();
      return {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en, dmem_if.mem_req, halted};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      start              = 1'b0;
      step_mode          = 1'b0;
      step               = 1'b0;
      icode              = 4'h1;
      ifun               = 4'h0;
      instr_valid        = 1'b1;
      imem_error         = 1'b0;
      dmem_if.mem_rdy    = 1'b0;
      dmem_if.dmem_error = 1'b0;
      sat_en             = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic run_prog(input int limit);
      int idx      = 0;
      int mem_wait = 0;
      int run      = 0;
      n_ticks = 0; cc_cycles = 0; memreq_cycles = 0; max_run = 0;
      n_fetch = 0; fetch_tick2 = 0; stat_at_fetch2 = 0; decode_seen = 1'b0;
      start = 1'b1;
      while (!halted && n_ticks < limit) begin
         tick();
         n_ticks++;
         if (fetch_en) begin
            n_fetch++;
            if (n_fetch == 2) begin
               fetch_tick2    = n_ticks;
               stat_at_fetch2 = int'(stat);
            end
            icode       = (idx < prog_len) ? prog[idx][3:0] : 4'h0;
            instr_valid = valid_flag;
            imem_error  = imem_flag;
            idx++;
         end
         if (decode_en) decode_seen = 1'b1;
         if (cc_en) cc_cycles++;
         if (dmem_if.mem_req) begin
            memreq_cycles++;
            run++;
            mem_wait++;
            if (run > max_run) max_run = run;
         end else begin
            run      = 0;
            mem_wait = 0;
         end
         dmem_if.mem_rdy    = (rdy_delay >= 0) && dmem_if.mem_req && (mem_wait == rdy_delay + 1);
         dmem_if.dmem_error = dmem_err_flag && dmem_if.mem_rdy;
      end
      start = 1'b0;
      checks++;
      if (!halted) begin
         errors++;
         $display("FAIL run_prog_bound halted=%0d after %0d cycles, want 1", halted, n_ticks);
      end
   endtask

   task automatic setup(input int p0, input int p1, input int p2, input int len);
      prog[0] = p0; prog[1] = p1; prog[2] = p2; prog_len = len;
      rdy_delay = -1; dmem_err_flag = 1'b0; valid_flag = 1'b1; imem_flag = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (outs() !== 9'b0) begin errors++; $display("FAIL reset_outs got %b want 0", outs()); end
      checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat got %0d want 1", stat); end
      checks++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin errors++;
         $display("FAIL reset_cnt got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
      tick();
      checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL idle_hold fetch_en got %0d want 0", fetch_en); end
   endtask

   task automatic test_basic_seq();
      setup(3, 6, 0, 3);
      do_reset();
      run_prog(40);
      checks++; if (n_ticks !== 13) begin errors++; $display("FAIL seq_latency got %0d want 13", n_ticks); end
      checks++; if (cc_cycles !== 1) begin errors++; $display("FAIL seq_cc_en got %0d want 1", cc_cycles); end
      checks++; if (instr_cnt !== 32'd2) begin errors++; $display("FAIL seq_instr_cnt got %0d want 2", instr_cnt); end
      checks++; if (stat !== 3'd2) begin errors++; $display("FAIL seq_stat got %0d want 2", stat); end
      checks++; if (cycle_cnt !== 32'd12) begin errors++; $display("FAIL seq_cycle_cnt got %0d want 12", cycle_cnt); end
      checks++; if (outs() !== 9'b000000001) begin errors++; $display("FAIL seq_halt_outs got %b want 000000001", outs()); end
      tick(); tick();
      checks++; if (cycle_cnt !== 32'd12 || !halted) begin errors++;
         $display("FAIL seq_halt_sticky got cnt=%0d halted=%0d want 12/1", cycle_cnt, halted); end
   endtask

   task automatic test_mem_wait();
      setup(5, 0, 0, 2);
      rdy_delay = 3;
      do_reset();
      run_prog(40);
      checks++; if (max_run !== 4) begin errors++; $display("FAIL memwait_req_run got %0d want 4", max_run); end
      checks++; if (fetch_tick2 - 1 !== 9) begin errors++; $display("FAIL memwait_latency got %0d want 9", fetch_tick2 - 1); end
      checks++; if (stat_at_fetch2 !== 1) begin errors++; $display("FAIL memwait_stat got %0d want 1", stat_at_fetch2); end
      checks++; if (cycle_cnt !== 32'd11 || instr_cnt !== 32'd1) begin errors++;
         $display("FAIL memwait_cnt got %0d/%0d want 11/1", cycle_cnt, instr_cnt); end
   endtask

   task automatic test_timeout();
      setup(4, 0, 0, 1);
      do_reset();
      run_prog(60);
      checks++; if (memreq_cycles !== 16) begin errors++; $display("FAIL timeout_mem_cycles got %0d want 16", memreq_cycles); end
      checks++; if (stat !== 3'd3) begin errors++; $display("FAIL timeout_stat got %0d want 3", stat); end
      checks++; if (dmem_if.mem_req !== 1'b0) begin errors++; $display("FAIL timeout_mem_req got %0d want 0", dmem_if.mem_req); end
      checks++; if (cycle_cnt !== 32'd19 || instr_cnt !== 32'd0) begin errors++;
         $display("FAIL timeout_cnt got %0d/%0d want 19/0", cycle_cnt, instr_cnt); end
   endtask

   task automatic test_rdy_at_timeout();
      setup(5, 0, 0, 2);
      rdy_delay = 15;
      do_reset();
      run_prog(60);
      checks++; if (memreq_cycles !== 16) begin errors++; $display("FAIL rdy_edge_mem_cycles got %0d want 16", memreq_cycles); end
      checks++; if (stat !== 3'd2 || stat_at_fetch2 !== 1) begin errors++;
         $display("FAIL rdy_edge_stat got %0d/%0d want 2/1", stat, stat_at_fetch2); end
      checks++; if (instr_cnt !== 32'd1 || cycle_cnt !== 32'd23) begin errors++;
         $display("FAIL rdy_edge_cnt got %0d/%0d want 1/23", instr_cnt, cycle_cnt); end
   endtask

   task automatic test_faults();
      setup(1, 0, 0, 1);
      valid_flag = 1'b0;
      do_reset();
      run_prog(20);
      checks++; if (n_ticks !== 2 || stat !== 3'd4) begin errors++;
         $display("FAIL ins_fault got ticks=%0d stat=%0d want 2/4", n_ticks, stat); end
      checks++; if (decode_seen !== 1'b0 || instr_cnt !== 32'd0) begin errors++;
         $display("FAIL ins_no_decode got dec=%0d icnt=%0d want 0/0", decode_seen, instr_cnt); end

      setup(1, 0, 0, 1);
      imem_flag = 1'b1;
      do_reset();
      run_prog(20);
      checks++; if (n_ticks !== 2 || stat !== 3'd3) begin errors++;
         $display("FAIL imem_fault got ticks=%0d stat=%0d want 2/3", n_ticks, stat); end

      setup(5, 0, 0, 1);
      rdy_delay = 0;
      dmem_err_flag = 1'b1;
      do_reset();
      run_prog(20);
      checks++; if (n_ticks !== 5 || stat !== 3'd3 || memreq_cycles !== 1) begin errors++;
         $display("FAIL dmem_fault got ticks=%0d stat=%0d req=%0d want 5/3/1", n_ticks, stat, memreq_cycles); end
   endtask

   task automatic test_step_mode();
      do_reset();
      step_mode = 1'b1;
      icode     = 4'h1;
      start     = 1'b1;
      tick(); tick(); tick();
      checks++; if (exec_en !== 1'b1) begin errors++; $display("FAIL step_exec got %0d want 1", exec_en); end
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL step_pcup got %0d want 1", pc_en); end
      tick(); tick(); tick();
      checks++; if (outs() !== 9'b0 || instr_cnt !== 32'd1 || cycle_cnt !== 32'd5) begin errors++;
         $display("FAIL step_paused got outs=%b icnt=%0d ccnt=%0d want 0/1/5", outs(), instr_cnt, cycle_cnt); end
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL step_release got %0d want 1", fetch_en); end
      tick(); tick(); tick(); tick(); tick();
      checks++; if (instr_cnt !== 32'd2 || outs() !== 9'b0 || cycle_cnt !== 32'd10) begin errors++;
         $display("FAIL step_second got icnt=%0d outs=%b ccnt=%0d want 2/0/10", instr_cnt, outs(), cycle_cnt); end
      start = 1'b0;
      step_mode = 1'b0;
   endtask

   task automatic test_reset_in_mem();
      do_reset();
      icode = 4'h5;
      start = 1'b1;
      tick(); tick(); tick(); tick();
      start = 1'b0;
      checks++; if (dmem_if.mem_req !== 1'b1) begin errors++; $display("FAIL rstmem_req got %0d want 1", dmem_if.mem_req); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (outs() !== 9'b0 || stat !== 3'd1 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin errors++;
         $display("FAIL rstmem_state got outs=%b stat=%0d cnt=%0d/%0d want 0/1/0/0", outs(), stat, cycle_cnt, instr_cnt); end
      tick();
      checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL rstmem_idle got %0d want 0", fetch_en); end
   endtask

   task automatic test_saturate();
      do_reset();
      sat_en = 1'b1;
      repeat (5) tick();
      checks++; if (sat_cnt !== 3'd5) begin errors++; $display("FAIL sat_count got %0d want 5", sat_cnt); end
      repeat (6) tick();
      checks++; if (sat_cnt !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d want 7", sat_cnt); end
      sat_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_seq();
      test_mem_wait();
      test_timeout();
      test_rdy_at_timeout();
      test_faults();
      test_step_mode();
      test_reset_in_mem();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
